// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed MIPS loads/stores into word accesses, with read-modify-write for sb/sh.
// Optional feature macro LSU_ALIGN_TRAP_EN: trap misaligned half/word accesses instead of force-aligning them.
module load_store_unit #(
  parameter int MEM_DEPTH = 32,
  parameter int IDX_W     = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        misalign
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STORE  = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_RESP   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  localparam logic [31:0] MEM_DEPTH_W = 32'(MEM_DEPTH);

  state_e           state_q, state_d;
  logic [1:0]       off_q, off_d;
  logic [1:0]       size_q, size_d;
  logic             signed_q, signed_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [4:0]       rd_q, rd_d;

  logic             ready_q, ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [4:0]       resp_rd_q, resp_rd_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             misalign_q, misalign_d;

  logic             accept_s;
  logic             misalign_req_s;
  logic [1:0]       req_off_s;
  logic [IDX_W-1:0] req_idx_s;
  logic             unused_s;

  // Select the addressed lane of a memory word and sign/zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half lane of a word, leaving the other lanes untouched.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic [15:0] data);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: begin
        case (off)
          2'd0:    r[7:0]   = data[7:0];
          2'd1:    r[15:8]  = data[7:0];
          2'd2:    r[23:16] = data[7:0];
          default: r[31:24] = data[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[31:16] = data;
        else        r[15:0]  = data;
      end
      default: r = word;
    endcase
    return r;
  endfunction

  assign req_idx_s = req_addr[IDX_W+1:2];
  assign accept_s  = req_valid & (state_q == S_IDLE) & (req_load | req_store);
  assign unused_s  = ^{req_addr[31:IDX_W+2], MEM_DEPTH_W};

`ifdef LSU_ALIGN_TRAP_EN
  assign misalign_req_s = ((req_size == 2'b01) & req_addr[0]) |
                          (req_size[1] & (req_addr[1:0] != 2'b00));
`else
  assign misalign_req_s = 1'b0;
`endif

  // Lane offset with low address bits forced to the access alignment.
  always_comb begin
    case (req_size)
      2'b00:   req_off_s = req_addr[1:0];
      2'b01:   req_off_s = {req_addr[1], 1'b0};
      default: req_off_s = 2'b00;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!accept_s)          state_d = S_IDLE;
        else if (misalign_req_s) state_d = S_ERR;
        else if (req_load)       state_d = S_LOAD;
        else if (req_size[1])    state_d = S_STORE;
        else                     state_d = S_RMW_RD;
      end
      S_LOAD:   state_d = S_RESP;
      S_RMW_RD: state_d = S_RMW_WR;
      S_STORE, S_RMW_WR, S_RESP, S_ERR: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Capture the accepted request; it must stay usable after upstream moves on.
  always_comb begin
    if (accept_s) begin
      off_d    = req_off_s;
      size_d   = req_size;
      signed_d = req_signed;
      wdata_d  = req_wdata[15:0];
      rd_d     = req_rd;
    end else begin
      off_d    = off_q;
      size_d   = size_q;
      signed_d = signed_q;
      wdata_d  = wdata_q;
      rd_d     = rd_q;
    end
  end

  // Output logic: every output flop is loaded from the state being entered.
  always_comb begin
    ready_d      = (state_d == S_IDLE);
    mem_read_d   = (state_d == S_LOAD) | (state_d == S_RMW_RD);
    mem_write_d  = (state_d == S_STORE) | (state_d == S_RMW_WR);
    resp_valid_d = (state_d == S_RESP);
`ifdef LSU_ALIGN_TRAP_EN
    misalign_d   = (state_d == S_ERR);
`else
    misalign_d   = 1'b0;
`endif
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    mem_wdata_d  = mem_wdata_q;
    if (accept_s && (state_d != S_ERR)) mem_addr_d = {{(32-IDX_W){1'b0}}, req_idx_s};
    else                                mem_addr_d = mem_addr_q;
    case (state_q)
      S_IDLE: begin
        if (state_d == S_STORE) mem_wdata_d = req_wdata;
        else                    mem_wdata_d = mem_wdata_q;
      end
      S_LOAD: begin
        resp_data_d = load_extend(mem_rdata, size_q, off_q, signed_q);
        resp_rd_d   = rd_q;
      end
      // The write-data register doubles as the merge register for sub-word stores.
      S_RMW_RD: mem_wdata_d = store_merge(mem_rdata, size_q, off_q, wdata_q);
      default:  mem_wdata_d = mem_wdata_q;
    endcase
  end

  // Request capture registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      off_q    <= 2'b00;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      wdata_q  <= 16'h0000;
      rd_q     <= 5'd0;
    end else begin
      off_q    <= off_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0000_0000;
      resp_rd_q    <= 5'd0;
      mem_addr_q   <= 32'h0000_0000;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= 32'h0000_0000;
      misalign_q   <= 1'b0;
    end else begin
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      mem_addr_q   <= mem_addr_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_wdata_q  <= mem_wdata_d;
      misalign_q   <= misalign_d;
    end
  end

  assign req_ready  = ready_q;
  assign stall      = req_valid & ~ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign mem_addr   = mem_addr_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_wdata  = mem_wdata_q;
  assign misalign   = misalign_q;

endmodule
